// File: rtl/select_bus_arb.sv
// select_bus_arb: clocked N_CH-way bus arbiter with a registered output and a
// valid/ready handshake. It selects one requesting source bus per transfer and
// drives the shared bus through an explicit output enable.
// Arbitration is round-robin (RR_MODE=1) or fixed priority with the lowest
// index winning (RR_MODE=0).
module select_bus_arb #(
    parameter  int WIDTH   = 16,
    parameter  int N_CH    = 4,
    parameter  bit RR_MODE = 1'b1,
    localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*WIDTH-1:0] bus_in,
    output logic [N_CH-1:0]       gnt,
    output logic [WIDTH-1:0]      busout,
    output logic                  busout_oe,
    output logic                  valid,
    input  logic                  ready,
    output logic [SEL_W-1:0]      sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Registered state and its next-state values.
    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     busout_q, busout_d;
    logic [SEL_W-1:0]     sel_q,    sel_d;
    logic [SEL_W-1:0]     ptr_q,    ptr_d;
    logic [N_CH-1:0]      gnt_q,    gnt_d;

    // Arbitration results.
    logic                 opp;
    logic                 win_found;
    logic [SEL_W-1:0]     win_idx;
    logic [WIDTH-1:0]     win_data;

    // The concatenated input bus, unpacked one slice per channel.
    logic [WIDTH-1:0]     bus_arr [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign bus_arr[gi] = bus_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Winner search: scan the channels starting at ptr and wrap around. In
    // fixed-priority mode ptr never leaves 0, so this same scan picks the
    // lowest set index.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(cand);
            end
        end
    end

    assign win_data = bus_arr[win_idx];

    // A new word can be captured only if the output slot is free or is being
    // emptied on this same edge.
    assign opp = enable && win_found && ((state_q == EMPTY) || ready);

    // Next-state logic. When a stall holds the output, every register keeps
    // its value and gnt stays low, whatever req and enable do.
    always_comb begin
        state_d  = state_q;
        busout_d = busout_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        if (opp) begin
            state_d  = FULL;
            busout_d = win_data;
            sel_d    = win_idx;
            gnt_d    = {{(N_CH-1){1'b0}}, 1'b1} << win_idx;
            if (RR_MODE) begin
                // Move the pointer to the channel after the winner so that
                // it has lowest priority on the next grant.
                if (win_idx == SEL_W'(N_CH-1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_idx + 1'b1;
                end
            end
        end else if ((state_q == FULL) && ready) begin
            // The held word is accepted and nothing replaces it. busout
            // keeps its last value, but busout_oe drops.
            state_d = EMPTY;
        end
    end

    // State register. Reset asserts asynchronously, so a pending word is
    // dropped at once, and reset releases on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            busout_q <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busout_q <= busout_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
        end
    end

    assign valid     = (state_q == FULL);
    assign busout_oe = (state_q == FULL);
    assign busout    = busout_q;
    assign sel       = sel_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_select_bus_arb.sv
// Directed bench for select_bus_arb. It drives one round-robin instance and
// one fixed-priority instance from the same stimulus. Every expected value is
// hand-computed from the arbitration rules.
module tb_select_bus_arb;

    localparam int WIDTH = 16;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  enable;
    logic [N_CH-1:0]       req;
    logic [N_CH*WIDTH-1:0] bus_in;
    logic                  ready;

    logic [N_CH-1:0]       rr_gnt,    fp_gnt;
    logic [WIDTH-1:0]      rr_busout, fp_busout;
    logic                  rr_oe,     fp_oe;
    logic                  rr_valid,  fp_valid;
    logic [SEL_W-1:0]      rr_sel,    fp_sel;

    int n_checks = 0;
    int n_fail   = 0;

    select_bus_arb #(.WIDTH(WIDTH), .N_CH(N_CH), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .bus_in(bus_in),
        .gnt(rr_gnt), .busout(rr_busout), .busout_oe(rr_oe), .valid(rr_valid),
        .ready(ready), .sel(rr_sel)
    );

    select_bus_arb #(.WIDTH(WIDTH), .N_CH(N_CH), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .bus_in(bus_in),
        .gnt(fp_gnt), .busout(fp_busout), .busout_oe(fp_oe), .valid(fp_valid),
        .ready(ready), .sel(fp_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count the result.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        bus_in = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] data_tab [4];
    logic [3:0]       stall_req [5];
    logic [1:0]       rr_alt [4];

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = '0;
        bus_in = '0;
        ready  = 1'b0;
        data_tab[0] = 16'h1111; data_tab[1] = 16'h2222;
        data_tab[2] = 16'h3333; data_tab[3] = 16'h4444;
        stall_req[0] = 4'b1110; stall_req[1] = 4'b1000; stall_req[2] = 4'b0110;
        stall_req[3] = 4'b1111; stall_req[4] = 4'b0101;
        rr_alt[0] = 2'd1; rr_alt[1] = 2'd3; rr_alt[2] = 2'd1; rr_alt[3] = 2'd3;

        // Reset state.
        step();
        step();
        check("rst_valid", 32'(rr_valid), 32'd0);
        check("rst_oe", 32'(rr_oe), 32'd0);
        check("rst_busout", 32'(rr_busout), 32'd0);
        check("rst_sel", 32'(rr_sel), 32'd0);
        check("rst_gnt", 32'(rr_gnt), 32'd0);
        rst_n = 1'b1;

        // Single request on channel 2: one-cycle latency.
        set_data(16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
        req = 4'b0100; enable = 1'b1; ready = 1'b1;
        step();
        $display("txn single: gnt=%b sel=%0d busout=%h valid=%b", rr_gnt, rr_sel, rr_busout, rr_valid);
        check("single_valid", 32'(rr_valid), 32'd1);
        check("single_busout", 32'(rr_busout), 32'hA5A5);
        check("single_sel", 32'(rr_sel), 32'd2);
        check("single_gnt", 32'(rr_gnt), 32'b0100);
        check("single_oe", 32'(rr_oe), 32'd1);
        req = 4'b0000;
        step();
        check("drain_valid", 32'(rr_valid), 32'd0);
        check("drain_gnt", 32'(rr_gnt), 32'd0);
        check("drain_busout_hold", 32'(rr_busout), 32'hA5A5);

        // Round-robin burst from a fresh pointer. The fixed-priority instance
        // keeps granting channel 0.
        do_reset();
        set_data(data_tab[0], data_tab[1], data_tab[2], data_tab[3]);
        req = 4'b1111; ready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            $display("txn rr%0d: gnt=%b sel=%0d busout=%h valid=%b", k, rr_gnt, rr_sel, rr_busout, rr_valid);
            check("rr_sel", 32'(rr_sel), 32'(k % 4));
            check("rr_gnt", 32'(rr_gnt), 32'(1) << (k % 4));
            check("rr_valid", 32'(rr_valid), 32'd1);
            check("rr_busout", 32'(rr_busout), 32'(data_tab[k % 4]));
            check("fp_sel_all", 32'(fp_sel), 32'd0);
        end
        // Round-robin pointer is now 1.
        req = 4'b0000;
        step();
        check("rr_drain_valid", 32'(rr_valid), 32'd0);

        // Fixed priority with req=1010: channel 1 every cycle. Round-robin
        // alternates 1,3,1,3 starting from pointer 1.
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            $display("txn fp%0d: fp_gnt=%b rr_gnt=%b", k, fp_gnt, rr_gnt);
            check("fp_gnt", 32'(fp_gnt), 32'b0010);
            check("fp_busout", 32'(fp_busout), 32'h2222);
            check("rr_alt_sel", 32'(rr_sel), 32'(rr_alt[k]));
        end
        // Round-robin pointer is now 0.
        req = 4'b0000;
        step();
        check("fp_drain_valid", 32'(fp_valid), 32'd0);

        // Stall: capture ch0=1234, then hold ready low for 5 cycles while the
        // requests change.
        set_data(16'h1234, data_tab[1], data_tab[2], data_tab[3]);
        req = 4'b0001;
        step();
        check("stall_cap_busout", 32'(rr_busout), 32'h1234);
        check("stall_cap_sel", 32'(rr_sel), 32'd0);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req = stall_req[k];
            step();
            $display("txn stall%0d: gnt=%b sel=%0d busout=%h valid=%b", k, rr_gnt, rr_sel, rr_busout, rr_valid);
            check("stall_valid", 32'(rr_valid), 32'd1);
            check("stall_busout", 32'(rr_busout), 32'h1234);
            check("stall_sel", 32'(rr_sel), 32'd0);
            check("stall_gnt", 32'(rr_gnt), 32'd0);
        end
        // The pointer is 1, so with req=0110 channel 1 wins on the accepting edge.
        req = 4'b0110; ready = 1'b1;
        step();
        check("unstall_sel", 32'(rr_sel), 32'd1);
        check("unstall_busout", 32'(rr_busout), 32'h2222);
        check("unstall_gnt", 32'(rr_gnt), 32'b0010);
        req = 4'b0000;
        step();

        // With enable low, requests are ignored but not lost.
        enable = 1'b0; req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            check("en_low_valid", 32'(rr_valid), 32'd0);
            check("en_low_gnt", 32'(rr_gnt), 32'd0);
        end
        enable = 1'b1;
        step();
        $display("txn enable: gnt=%b sel=%0d busout=%h", rr_gnt, rr_sel, rr_busout);
        check("en_ret_gnt", 32'(rr_gnt), 32'b0001);
        check("en_ret_busout", 32'(rr_busout), 32'h1234);
        // Drop enable while FULL: the word holds, then completes on ready.
        enable = 1'b0; ready = 1'b0;
        step();
        check("en_full_hold", 32'(rr_valid), 32'd1);
        ready = 1'b1;
        step();
        check("en_full_accept_valid", 32'(rr_valid), 32'd0);
        check("en_full_accept_gnt", 32'(rr_gnt), 32'd0);
        check("en_full_busout_hold", 32'(rr_busout), 32'h1234);

        // Asynchronous reset mid-burst (the pointer is 1, so channel 1 is captured first).
        enable = 1'b1; req = 4'b1111; ready = 1'b1;
        step();
        check("pre_rst_sel", 32'(rr_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rr_valid), 32'd0);
        check("async_rst_oe", 32'(rr_oe), 32'd0);
        check("async_rst_gnt", 32'(rr_gnt), 32'd0);
        check("async_rst_busout", 32'(rr_busout), 32'd0);
        rst_n = 1'b1;
        step();
        $display("txn post_rst: gnt=%b sel=%0d busout=%h", rr_gnt, rr_sel, rr_busout);
        check("post_rst_sel", 32'(rr_sel), 32'd0);
        check("post_rst_gnt", 32'(rr_gnt), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
